// File: rtl/spi_master_burst.sv
// Burst-capable SPI mode-3 master with per-word streaming handshakes and multiple chip selects.
// Define SPI_CS_GAP_EN to hold cs_n high for CS_GAP clk cycles after each frame before returning to IDLE.
module spi_master_burst #(
  parameter int CLK_HZ    = 50_000_000,
  parameter int SPI_CLK   = 5_000_000,
  parameter int ADDR_W    = 7,
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 16,
  parameter int NUM_CS    = 1,
  parameter int CS_GAP    = 8
) (
  input  logic                                         clk,
  input  logic                                         rst,
  input  logic                                         enable,
  input  logic                                         start,
  input  logic                                         rw,
  input  logic [((NUM_CS > 1) ? $clog2(NUM_CS) : 1)-1:0] cs_sel,
  input  logic [ADDR_W-1:0]                            reg_addr,
  input  logic [$clog2(MAX_BURST+1)-1:0]               burst_len,
  input  logic [DATA_W-1:0]                            tx_data,
  output logic                                         tx_ready,
  output logic [DATA_W-1:0]                            rx_data,
  output logic                                         rx_valid,
  output logic                                         busy,
  output logic                                         done,
  output logic                                         sclk,
  output logic                                         mosi,
  input  logic                                         miso,
  output logic [NUM_CS-1:0]                            cs_n
);

  localparam int CSW     = (NUM_CS > 1) ? $clog2(NUM_CS) : 1;
  localparam int LW      = $clog2(MAX_BURST + 1);
  localparam int DIV     = CLK_HZ / (2 * SPI_CLK);
  localparam int CNT_MAX = (DIV > CS_GAP) ? DIV : CS_GAP;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int HW      = $clog2(ADDR_W + 2);
  localparam int DW      = $clog2(DATA_W + 1);

  localparam logic [CW-1:0] DIV_LAST  = CW'(DIV - 1);
  localparam logic [DW-1:0] DBIT_LAST = DW'(DATA_W - 1);
  localparam logic [HW-1:0] HDR_DATA  = HW'(ADDR_W + 1);
`ifdef SPI_CS_GAP_EN
  localparam logic [CW-1:0] GAP_LAST  = CW'(CS_GAP - 1);
`endif

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, GAP} state_t;

  state_t            state;
  logic [CW-1:0]     cnt;
  logic              sclk_hi;
  logic [HW-1:0]     hdr_cnt;
  logic [DW-1:0]     dbit;
  logic [LW-1:0]     word;
  logic [LW-1:0]     last_word;
  logic              rw_q;
  logic [ADDR_W-1:0] addr_sh;
  logic [DATA_W-1:0] tx_sh;
  logic [DATA_W-2:0] rx_sh;
  logic [DATA_W-1:0] rx_next;
  logic              in_data;

  // Header is the R/W bit plus ADDR_W address bits; hdr_cnt parks at ADDR_W+1 once data starts.
  assign in_data = (hdr_cnt == HDR_DATA);
  assign rx_next = {rx_sh, miso};

  function automatic logic [LW-1:0] last_word_of(input logic [LW-1:0] len);
    if (len == '0)
      return '0;
    else if (len > LW'(MAX_BURST))
      return LW'(MAX_BURST - 1);
    else
      return len - 1'b1;
  endfunction

  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CSW-1:0] sel);
    return ~(NUM_CS'(1) << sel);
  endfunction

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      sclk_hi   <= 1'b0;
      hdr_cnt   <= '0;
      dbit      <= '0;
      word      <= '0;
      last_word <= '0;
      rw_q      <= 1'b0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      tx_ready  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      sclk      <= 1'b1;
      mosi      <= 1'b1;
      cs_n      <= '1;
    end else begin
      done     <= 1'b0;
      rx_valid <= 1'b0;
      tx_ready <= 1'b0;
      if (state != IDLE && !enable) begin
        state <= IDLE;
        cs_n  <= '1;
        sclk  <= 1'b1;
        mosi  <= 1'b1;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy <= 1'b0;
            if (start && enable) begin
              state     <= SETUP;
              busy      <= 1'b1;
              cnt       <= '0;
              sclk_hi   <= 1'b0;
              hdr_cnt   <= '0;
              dbit      <= '0;
              word      <= '0;
              last_word <= last_word_of(burst_len);
              rw_q      <= rw;
              addr_sh   <= reg_addr;
              tx_sh     <= tx_data;
              cs_n      <= cs_decode(cs_sel);
              mosi      <= rw;
              sclk      <= 1'b1;
            end
          end
          SETUP: begin
            if (cnt == DIV_LAST) begin
              cnt   <= '0;
              state <= SHIFT;
              sclk  <= 1'b0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          SHIFT: begin
            // tx_ready is visible for exactly one cycle; the word offered then feeds the next falling edge.
            if (tx_ready)
              tx_sh <= tx_data;
            if (cnt != DIV_LAST) begin
              cnt <= cnt + 1'b1;
            end else begin
              cnt <= '0;
              if (!sclk_hi) begin
                sclk    <= 1'b1;
                sclk_hi <= 1'b1;
                if (in_data) begin
                  rx_sh <= rx_next[DATA_W-2:0];
                  if (dbit == DBIT_LAST) begin
                    if (rw_q) begin
                      rx_data  <= rx_next;
                      rx_valid <= 1'b1;
                    end else if (word != last_word) begin
                      tx_ready <= 1'b1;
                    end
                  end
                end
              end else begin
                sclk_hi <= 1'b0;
                if (in_data && dbit == DBIT_LAST && word == last_word) begin
                  state <= HOLD;
                end else begin
                  sclk <= 1'b0;
                  if (!in_data)
                    hdr_cnt <= hdr_cnt + 1'b1;
                  else if (dbit == DBIT_LAST) begin
                    dbit <= '0;
                    word <= word + 1'b1;
                  end else
                    dbit <= dbit + 1'b1;
                  if (hdr_cnt < HW'(ADDR_W)) begin
                    mosi    <= addr_sh[ADDR_W-1];
                    addr_sh <= addr_sh << 1;
                  end else if (rw_q) begin
                    mosi <= 1'b0;
                  end else begin
                    mosi  <= tx_sh[DATA_W-1];
                    tx_sh <= tx_sh << 1;
                  end
                end
              end
            end
          end
          HOLD: begin
            if (cnt == DIV_LAST) begin
              cnt  <= '0;
              cs_n <= '1;
              done <= 1'b1;
`ifdef SPI_CS_GAP_EN
              state <= GAP;
`else
              state <= IDLE;
`endif
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`ifdef SPI_CS_GAP_EN
          GAP: begin
            if (cnt == GAP_LAST) begin
              cnt   <= '0;
              state <= IDLE;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
`endif
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_master_burst.sv
// Scoreboard bench for spi_master_burst: stimulus queues expected MOSI bits, read words and frame shapes; monitors pop and compare.
module tb_spi_master_burst;

  logic       clk = 1'b0;
  logic       rst, enable, start, rw, miso;
  logic [0:0] cs_sel;
  logic [6:0] reg_addr;
  logic [4:0] burst_len;
  logic [7:0] tx_data;
  logic       tx_ready, rx_valid, busy, done, sclk, mosi;
  logic [7:0] rx_data;
  logic [0:0] cs_n;

  spi_master_burst dut (
    .clk(clk), .rst(rst), .enable(enable), .start(start), .rw(rw), .cs_sel(cs_sel),
    .reg_addr(reg_addr), .burst_len(burst_len), .tx_data(tx_data), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .done(done), .sclk(sclk),
    .mosi(mosi), .miso(miso), .cs_n(cs_n)
  );

  always #5 clk = ~clk;

  typedef struct { int rises; int low; } frame_t;

  int         checks = 0;
  int         errors = 0;
  bit         exp_mosi[$];
  logic [7:0] exp_rx[$];
  frame_t     exp_frame[$];
  logic [7:0] txq[$];
  logic [7:0] wr_words[16];
  logic [7:0] slave_words[16];
  int         rises = 0, low_cyc = 0, done_cnt = 0, txr_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: MOSI on every SCLK rise, read words on rx_valid, frame shape on cs_n rise.
  initial begin
    logic   prev_sclk, prev_cs;
    frame_t f;
    prev_sclk = 1'b1;
    prev_cs   = 1'b1;
    forever begin
      @(negedge clk);
      if (prev_cs && !cs_n[0]) begin
        rises   = 0;
        low_cyc = 0;
      end
      if (!cs_n[0]) low_cyc++;
      if (!cs_n[0] && sclk && !prev_sclk) begin
        rises++;
        if (exp_mosi.size() > 0) check($sformatf("mosi_bit%0d", rises - 1), mosi, exp_mosi.pop_front());
      end
      if (cs_n[0] && !prev_cs && exp_frame.size() > 0) begin
        f = exp_frame.pop_front();
        check("frame_rises", rises, f.rises);
        check("frame_cs_low", low_cyc, f.low);
      end
      if (rx_valid) begin
        if (exp_rx.size() == 0) check("rx_unexpected", 1, 0);
        else check("rx_data", rx_data, exp_rx.pop_front());
      end
      if (done) done_cnt++;
      prev_sclk = sclk;
      prev_cs   = cs_n[0];
    end
  end

  // Write-word supplier answering tx_ready.
  initial begin
    forever begin
      @(negedge clk);
      if (tx_ready) begin
        txr_cnt++;
        if (txq.size() > 0) tx_data = txq.pop_front();
      end
    end
  end

  // Mode-3 slave: shifts the next bit out on each SCLK fall; data words follow the 8-bit header.
  initial begin
    logic sp;
    int   fall;
    sp   = 1'b1;
    fall = 0;
    miso = 1'b1;
    forever begin
      @(negedge clk);
      if (cs_n[0]) fall = 0;
      else if (sp && !sclk) begin
        if (fall >= 8) miso = slave_words[((fall - 8) / 8) % 16][7 - ((fall - 8) % 8)];
        else miso = 1'b1;
        fall++;
      end
      sp = sclk;
    end
  end

  task automatic push_exp(input logic r, input logic [6:0] a, input int L, input int er, input int el);
    frame_t f;
    exp_mosi.push_back(r);
    for (int i = 6; i >= 0; i--) exp_mosi.push_back(a[i]);
    for (int w = 0; w < L; w++)
      for (int b = 7; b >= 0; b--) exp_mosi.push_back(r ? 1'b0 : wr_words[w][b]);
    if (r) for (int w = 0; w < L; w++) exp_rx.push_back(8'h10 + 8'(w));
    f.rises = er;
    f.low   = el;
    exp_frame.push_back(f);
    txq.delete();
    if (!r) for (int w = 1; w < L; w++) txq.push_back(wr_words[w]);
  endtask

  task automatic wait_done(input string name);
    int n;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check({name, "_done_seen"}, done, 1);
    check({name, "_busy_at_done"}, busy, 1);
    @(negedge clk);
    check({name, "_busy_low"}, busy, 0);
    check({name, "_cs_high"}, cs_n, 1);
  endtask

  task automatic run_txn(input string name, input logic r, input logic [6:0] a, input logic [4:0] blen,
                         input int L, input int er, input int el, input bit poke);
    int txr0;
    push_exp(r, a, L, er, el);
    txr0 = txr_cnt;
    @(negedge clk);
    rw = r; reg_addr = a; burst_len = blen; tx_data = wr_words[0]; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check({name, "_busy"}, busy, 1);
    if (poke) begin
      repeat (60) @(negedge clk);
      rw = ~r; start = 1'b1;
      @(negedge clk);
      start = 1'b0; rw = r;
    end
    wait_done(name);
    @(negedge clk);
    check({name, "_tx_ready_pulses"}, txr_cnt - txr0, r ? 0 : L - 1);
    check({name, "_mosi_left"}, exp_mosi.size(), 0);
    check({name, "_rx_left"}, exp_rx.size(), 0);
    check({name, "_frame_left"}, exp_frame.size(), 0);
  endtask

  task automatic check_reset_vals(input string name);
    check({name, "_cs_n"}, cs_n, 1);
    check({name, "_sclk"}, sclk, 1);
    check({name, "_mosi"}, mosi, 1);
    check({name, "_busy"}, busy, 0);
    check({name, "_done"}, done, 0);
    check({name, "_tx_ready"}, tx_ready, 0);
    check({name, "_rx_valid"}, rx_valid, 0);
    check({name, "_rx_data"}, rx_data, 0);
  endtask

  initial begin
    int n, d0;
    rst = 1'b1; enable = 1'b1; start = 1'b0; rw = 1'b0; cs_sel = 1'b0;
    reg_addr = '0; burst_len = '0; tx_data = '0;
    for (int i = 0; i < 16; i++) begin
      slave_words[i] = 8'h10 + 8'(i);
      wr_words[i]    = '0;
    end
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Single write: 0,1001011,00000001 -> 16 rises, 170 cycles of cs_n low.
    wr_words[0] = 8'h01;
    run_txn("wr1", 1'b0, 7'h4B, 5'd1, 1, 16, 170, 1'b0);

    // Burst read of eight words 0x10..0x17.
    run_txn("rd8", 1'b1, 7'h42, 5'd8, 8, 72, 730, 1'b0);

    // Burst write with a stray start mid-frame that must be ignored.
    wr_words[0] = 8'hA5; wr_words[1] = 8'h5A; wr_words[2] = 8'hFF;
    run_txn("wr3", 1'b0, 7'h30, 5'd3, 3, 32, 330, 1'b1);

    // burst_len 0 behaves as a single word.
    wr_words[0] = 8'h3C;
    run_txn("wr0", 1'b0, 7'h7F, 5'd0, 1, 16, 170, 1'b0);

    // burst_len 31 saturates to 16 words.
    run_txn("rdsat", 1'b1, 7'h00, 5'd31, 16, 136, 1370, 1'b0);

    // Reset in the middle of a read frame.
    @(negedge clk);
    rw = 1'b1; reg_addr = 7'h11; burst_len = 5'd2; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rises < 5 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("midrst_cs_low_before", cs_n, 0);
    rst = 1'b1;
    @(negedge clk);
    check_reset_vals("midrst");
    rst = 1'b0;
    repeat (3) @(negedge clk);

    // Enable dropped after 20 rises of a 4-word read: only word 0 is delivered.
    exp_mosi.push_back(1'b1);
    for (int i = 6; i >= 0; i--) exp_mosi.push_back(reg_addr[i] & 1'b0 | (7'h42 >> i) & 7'h1);
    for (int i = 0; i < 12; i++) exp_mosi.push_back(1'b0);
    exp_rx.push_back(8'h10);
    d0 = done_cnt;
    @(negedge clk);
    rw = 1'b1; reg_addr = 7'h42; burst_len = 5'd4; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (rises < 20 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("abort_reached_20", (rises >= 20), 1);
    enable = 1'b0;
    @(negedge clk);
    check("abort_cs_n", cs_n, 1);
    check("abort_sclk", sclk, 1);
    check("abort_mosi", mosi, 1);
    check("abort_busy", busy, 0);
    repeat (20) @(negedge clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_rx_left", exp_rx.size(), 0);
    check("abort_mosi_left", exp_mosi.size(), 0);
    enable = 1'b1;
    repeat (2) @(negedge clk);

`ifdef SPI_CS_GAP_EN
    // Back-to-back frames: cs_n must stay high for at least CS_GAP cycles.
    wr_words[0] = 8'h01;
    push_exp(1'b0, 7'h4B, 1, 16, 170);
    push_exp(1'b0, 7'h4B, 1, 16, 170);
    txq.delete();
    @(negedge clk);
    rw = 1'b0; reg_addr = 7'h4B; burst_len = 5'd1; tx_data = 8'h01; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (30) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (!done && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check("gap_first_done", done, 1);
    start = 1'b1;
    n = 0;
    while (cs_n[0] && n < 100) begin
      @(negedge clk);
      n++;
    end
    start = 1'b0;
    checks++;
    if (n < 8) begin
      errors++;
      $display("FAIL gap_cycles actual=%0d required>=8", n);
    end
    wait_done("gap2");
    @(negedge clk);
    check("gap_frame_left", exp_frame.size(), 0);
    check("gap_mosi_left", exp_mosi.size(), 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
